bpt_resolve_queue: RTL

//  In-order queue of in-flight branch predictions, between fetch and execute.

---
 rtl/bpt_resolve_queue_pkg.sv | 22 ++
 rtl/bpq_fifo.sv | 70 +++++++
 rtl/bpt_resolve_queue.sv | 75 +++++++
 3 files changed

// File: rtl/bpt_resolve_queue_pkg.sv
// Shared types for the branch-prediction resolve queue.
// Defines the PC word, the queued entry and the mispredict rule.
package bpt_resolve_queue_pkg;

    localparam int WORD_W    = 32;
    localparam int DEPTH_DEF = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t pc;
        logic  taken;
        word_t target;
    } bpq_entry_t;

    // A not-taken branch has no target to compare against.
    function automatic logic is_mispredict(input bpq_entry_t e, input logic taken,
                                           input word_t target);
        return (taken != e.taken) || (taken && (target != e.target));
    endfunction

endpackage

// File: rtl/bpq_fifo.sv
// In-order storage for in-flight predictions: head/tail/count with push, pop and flush.
// A push is accepted when full only if a pop frees the slot in the same cycle.
module bpq_fifo
    import bpt_resolve_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       push,
    input  logic       pop,
    input  logic       clear,
    input  bpq_entry_t wdata,
    output bpq_entry_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] bpq_ptr_t;
    typedef logic [CW-1:0] bpq_cnt_t;

    localparam bpq_cnt_t FULL_CNT = bpq_cnt_t'(DEPTH);

    bpq_entry_t mem [DEPTH];
    bpq_ptr_t   head;
    bpq_ptr_t   tail;
    bpq_cnt_t   count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[head];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            // A flush drops every entry, including any push in the same cycle.
            head  <= tail;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + bpq_ptr_t'(1);
            end
            if (do_pop) begin
                head <= head + bpq_ptr_t'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + bpq_cnt_t'(1);
                2'b01:   count <= count - bpq_cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !clear) begin
            mem[tail] <= wdata;
        end
    end

endmodule

// File: rtl/bpt_resolve_queue.sv
// Resolve queue between fetch and execute: compares the oldest prediction with the
// actual outcome, drives the predictor-table update and a one-cycle redirect.
module bpt_resolve_queue
    import bpt_resolve_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  pred_valid,
    input  word_t pred_pc,
    input  logic  pred_taken,
    input  word_t pred_target,
    output logic  q_full,
    output logic  q_empty,
    input  logic  res_valid,
    input  logic  res_taken,
    input  word_t res_target,
    output word_t pc_res,
    output logic  taken_res,
    output logic  enable_res,
    output logic  mispredict,
    output word_t redirect_pc,
    output logic  res_err
);

    bpq_entry_t push_entry;
    bpq_entry_t head_entry;
    logic       do_res;
    logic       mis_now;

    assign push_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};
    assign do_res     = res_valid && !q_empty;
    assign mis_now    = do_res && is_mispredict(head_entry, res_taken, res_target);

    bpq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .push  (pred_valid),
        .pop   (do_res),
        .clear (mis_now),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (q_full),
        .empty (q_empty)
    );

    // Update port and redirect hold their last values between pulses.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_res      <= '0;
            taken_res   <= 1'b0;
            enable_res  <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            res_err     <= 1'b0;
        end else begin
            enable_res <= do_res;
            mispredict <= mis_now;
            if (do_res) begin
                pc_res    <= head_entry.pc;
                taken_res <= res_taken;
            end
            if (mis_now) begin
                redirect_pc <= res_target;
            end
            if (res_valid && q_empty) begin
                res_err <= 1'b1;
            end
        end
    end

endmodule
